counter_delta_decoder: RTL and testbench

COUNTER_DELTA_DECODER -- requirements
Module: counter_delta_decoder

---
 rtl/counter_delta_decoder.sv | 119 +++++++++++
 tb/tb_counter_delta_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_delta_decoder.sv
// counter_delta_decoder: recovers per-sample increments from a sampled 8-bit free-running counter.
// Define DELTA_STALL_DET_EN to build the consecutive-zero-delta stall detector.
module counter_delta_decoder #(
   parameter int TOTAL_W     = 16,
   parameter int STALL_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         counter_value,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         max_delta,
   output logic [7:0]         delta_out,
   output logic               delta_valid,
   input  logic               delta_ready,
   output logic [TOTAL_W-1:0] total_out,
   output logic               err,
   output logic               stall,
   output logic               state_dbg
);

   typedef enum logic {
      EMPTY  = 1'b0,
      PRIMED = 1'b1
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [7:0] ref_q;
   logic [7:0] delta_calc;
   logic       accept;
   logic       load_ref;
   logic       load_delta;

   // Handshake: a transfer happens on a posedge where valid && ready. A producer holds its
   // data stable while valid && !ready. Input side is ready whenever the output slot is
   // empty or being drained this cycle, and never during reset.
   assign in_ready   = !rst && (!delta_valid || delta_ready);
   assign accept     = in_valid && in_ready;
   assign delta_calc = counter_value - ref_q;
   assign state_dbg  = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = PRIMED;
      end
   end

   always_comb begin
      load_ref   = 1'b0;
      load_delta = 1'b0;
      case (state_q)
         EMPTY:   load_ref = accept;
         PRIMED: begin
            load_ref   = accept;
            load_delta = accept;
         end
         default: begin
            load_ref   = 1'b0;
            load_delta = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_q       <= '0;
         delta_out   <= '0;
         delta_valid <= 1'b0;
         total_out   <= '0;
         err         <= 1'b0;
      end else begin
         if (load_ref) begin
            ref_q <= counter_value;
         end
         if (load_delta) begin
            // A new delta may replace one being delivered in the same cycle.
            delta_out   <= delta_calc;
            delta_valid <= 1'b1;
            total_out   <= total_out + TOTAL_W'(delta_calc);
            if (delta_calc > max_delta) begin
               err <= 1'b1;
            end
         end else if (delta_ready) begin
            delta_valid <= 1'b0;
         end
      end
   end

`ifdef DELTA_STALL_DET_EN
   logic [7:0] zero_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_cnt <= '0;
      end else if (load_delta) begin
         if (delta_calc != 8'd0) begin
            zero_cnt <= '0;
         end else if (zero_cnt != 8'hFF) begin
            zero_cnt <= zero_cnt + 8'd1;
         end
      end
   end

   assign stall = (zero_cnt >= 8'(STALL_LIMIT));
`else
   assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_counter_delta_decoder.sv
// tb_counter_delta_decoder: directed vectors plus hand-written multi-cycle sequences
// for counter_delta_decoder (default parameters).
module tb_counter_delta_decoder;

  localparam int TOTAL_W     = 16;
  localparam int STALL_LIMIT = 4;
`ifdef DELTA_STALL_DET_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [7:0]         counter_value;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         max_delta;
  logic [7:0]         delta_out;
  logic               delta_valid;
  logic               delta_ready;
  logic [TOTAL_W-1:0] total_out;
  logic               err;
  logic               stall;
  logic               state_dbg;

  counter_delta_decoder #(
    .TOTAL_W     (TOTAL_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .counter_value (counter_value),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .max_delta     (max_delta),
    .delta_out     (delta_out),
    .delta_valid   (delta_valid),
    .delta_ready   (delta_ready),
    .total_out     (total_out),
    .err           (err),
    .stall         (stall),
    .state_dbg     (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        rst;
    logic [7:0]  cv;
    logic        iv;
    logic        dr;
    logic [7:0]  maxd;
    logic        ir;
    logic        dv;
    logic [7:0]  d;
    logic [15:0] total;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    in_valid    = 1'b0;
    delta_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    rst           = v.rst;
    counter_value = v.cv;
    in_valid      = v.iv;
    delta_ready   = v.dr;
    max_delta     = v.maxd;
    #1;
    check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.ir));
    tick();
    check($sformatf("v%0d delta_valid", idx), 32'(delta_valid), 32'(v.dv));
    check($sformatf("v%0d delta_out", idx), 32'(delta_out), 32'(v.d));
    check($sformatf("v%0d total_out", idx), 32'(total_out), 32'(v.total));
    check($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
  endtask

  initial begin
    logic [7:0] cv;
    n_cmp         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    counter_value = 8'd0;
    in_valid      = 1'b0;
    delta_ready   = 1'b1;
    max_delta     = 8'd255;

    //               rst   cv      iv    dr    maxd     ir    dv    d       total     err
    vecs[0]  = '{1'b1, 8'd0,   1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 8'd0,   16'd0,  1'b0};
    vecs[1]  = '{1'b0, 8'd120, 1'b1, 1'b1, 8'd255, 1'b1, 1'b0, 8'd0,   16'd0,  1'b0};
    vecs[2]  = '{1'b0, 8'd125, 1'b1, 1'b1, 8'd255, 1'b1, 1'b1, 8'd5,   16'd5,  1'b0};
    vecs[3]  = '{1'b0, 8'd130, 1'b1, 1'b1, 8'd255, 1'b1, 1'b1, 8'd5,   16'd10, 1'b0};
    vecs[4]  = '{1'b0, 8'd130, 1'b0, 1'b1, 8'd255, 1'b1, 1'b0, 8'd5,   16'd10, 1'b0};
    vecs[5]  = '{1'b1, 8'd0,   1'b0, 1'b1, 8'd8,   1'b0, 1'b0, 8'd0,   16'd0,  1'b0};
    vecs[6]  = '{1'b0, 8'd250, 1'b1, 1'b1, 8'd8,   1'b1, 1'b0, 8'd0,   16'd0,  1'b0};
    vecs[7]  = '{1'b0, 8'd4,   1'b1, 1'b1, 8'd8,   1'b1, 1'b1, 8'd10,  16'd10, 1'b1};
    vecs[8]  = '{1'b0, 8'd6,   1'b1, 1'b1, 8'd8,   1'b1, 1'b1, 8'd2,   16'd12, 1'b1};
    vecs[9]  = '{1'b0, 8'd9,   1'b1, 1'b1, 8'd8,   1'b1, 1'b1, 8'd3,   16'd15, 1'b1};
    vecs[10] = '{1'b0, 8'd9,   1'b0, 1'b1, 8'd8,   1'b1, 1'b0, 8'd3,   16'd15, 1'b1};

    for (int i = 0; i < 11; i++) begin
      apply_vec(vecs[i], i);
    end
    rst = 1'b0;

    // Backpressure: delta 7 held while downstream stalls, then delivery and accept together.
    max_delta = 8'd255;
    do_reset();
    in_valid = 1'b1; counter_value = 8'd10; tick();
    counter_value = 8'd17; tick();
    check("bp first delta", 32'(delta_out), 32'd7);
    delta_ready   = 1'b0;
    counter_value = 8'd20;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
      tick();
      check($sformatf("bp hold%0d delta_out", k), 32'(delta_out), 32'd7);
      check($sformatf("bp hold%0d delta_valid", k), 32'(delta_valid), 32'd1);
      check($sformatf("bp hold%0d total", k), 32'(total_out), 32'd7);
    end
    delta_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp release delta_out", 32'(delta_out), 32'd3);
    check("bp release delta_valid", 32'(delta_valid), 32'd1);
    check("bp release total", 32'(total_out), 32'd10);
    in_valid = 1'b0;
    tick();
    check("bp drain delta_valid", 32'(delta_valid), 32'd0);

    // Stall detector: reference 42 then four zero deltas, then a nonzero delta.
    do_reset();
    check("stall after reset", 32'(stall), 32'd0);
    in_valid = 1'b1; counter_value = 8'd42; tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("stall zero%0d delta_out", k), 32'(delta_out), 32'd0);
      check($sformatf("stall zero%0d delta_valid", k), 32'(delta_valid), 32'd1);
      check($sformatf("stall zero%0d stall", k), 32'(stall),
            32'(STALL_EN && (k >= STALL_LIMIT)));
    end
    counter_value = 8'd43; tick();
    check("stall clear delta_out", 32'(delta_out), 32'd1);
    check("stall clear stall", 32'(stall), 32'd0);
    in_valid = 1'b0;

    // Reset with an undelivered delta, total 300 and err set; in-flight sample is dropped.
    max_delta = 8'd8;
    do_reset();
    in_valid = 1'b1; counter_value = 8'd0;   tick();
    counter_value = 8'd200; tick();
    counter_value = 8'd44;  tick();
    in_valid = 1'b0; delta_ready = 1'b0; tick();
    check("rst pre total", 32'(total_out), 32'd300);
    check("rst pre delta_valid", 32'(delta_valid), 32'd1);
    check("rst pre err", 32'(err), 32'd1);
    rst = 1'b1; in_valid = 1'b1; counter_value = 8'd77;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("rst post delta_valid", 32'(delta_valid), 32'd0);
    check("rst post delta_out", 32'(delta_out), 32'd0);
    check("rst post total", 32'(total_out), 32'd0);
    check("rst post err", 32'(err), 32'd0);
    check("rst post stall", 32'(stall), 32'd0);
    check("rst post state", 32'(state_dbg), 32'd0);
    max_delta = 8'd255; delta_ready = 1'b1; counter_value = 8'd9; tick();
    check("rst first sample delta_valid", 32'(delta_valid), 32'd0);
    check("rst first sample state", 32'(state_dbg), 32'd1);
    check("rst first sample total", 32'(total_out), 32'd0);
    counter_value = 8'd12; tick();
    check("rst second sample delta_out", 32'(delta_out), 32'd3);
    check("rst second sample total", 32'(total_out), 32'd3);
    in_valid = 1'b0;

    // Total wrap: 256 deltas of 255, one of 250 (65530), then 250 -> 4 gives delta 10.
    do_reset();
    cv = 8'd0;
    in_valid = 1'b1; counter_value = cv; tick();
    for (int k = 0; k < 256; k++) begin
      cv = cv - 8'd1;
      counter_value = cv;
      tick();
    end
    check("wrap total 65280", 32'(total_out), 32'd65280);
    counter_value = 8'd250; tick();
    check("wrap total 65530", 32'(total_out), 32'd65530);
    counter_value = 8'd4; tick();
    check("wrap delta_out", 32'(delta_out), 32'd10);
    check("wrap total", 32'(total_out), 32'd4);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
